seq_bit_serializer: RTL
=======================

// Module: seq_bit_serializer
// PURPOSE
//   Upstream feeder for the 1011 sequence detector. Accepts parallel words over a
//   valid/ready handshake and shifts them out one bit per enabled cycle on out_bit.
//   out_bit drives the detector's inp_bit. A one-entry holding buffer allows
//   back-to-back words with no idle bit between them.
// PARAMETERS
//   DATA_W     8   width of each input word, in bits (>= 2)
//   MSB_FIRST  1   1: in_data[DATA_W-1] is sent first; 0: in_data[0] is sent first
// PORTS
//   clk        in   1        single clock; all state changes on posedge
//   reset      in   1        asynchronous, active-high; clears all state
//   in_data    in   DATA_W   word to serialize
//   in_valid   in   1        in_data is valid this cycle
//   in_ready   out  1        block can take a word; transfer when in_valid & in_ready
//   bit_en     in   1        pacing strobe; the shifter advances only when high
//   out_bit    out  1        current serial bit (inp_bit of the detector)
//   out_valid  out  1        out_bit carries payload this cycle
//   frame_done out  1        one-cycle pulse: last bit of a word consumed
//   busy       out  1        shifter or holding buffer occupied
// BEHAVIOUR
//   Reset values: in_ready=1, out_bit=0, out_valid=0, frame_done=0, busy=0.
//     Bit counter=0, FSM=IDLE, hold buffer empty.
//   Reset is asserted mid-word: the partial word and the held word are dropped.
//     No frame_done is issued. Serialization restarts cleanly after reset is released.
//   in_ready = !hold_full. It is registered and has no combinational path from in_valid.
//   FSM states:
//     IDLE:  shifter empty. An accepted word loads the shifter directly (not the hold
//            buffer) and moves to SHIFT. The first bit appears on out_bit the next cycle.
//     SHIFT: out_valid=1 and out_bit=current bit. On a cycle with bit_en=1 the bit is
//            consumed and the counter increments. When bit_en=0, out_bit and the counter hold.
//   End of word (bit_en=1 and counter==DATA_W-1):
//     frame_done=1 that cycle.
//     If hold_full: the hold word moves into the shifter, the counter goes to 0, the FSM
//       stays in SHIFT, and the hold buffer empties. The next word's first bit is
//       presented the very next cycle, with no gap.
//     Otherwise the FSM goes to IDLE, and out_valid=0 and out_bit=0 from the next cycle.
//   Accept while in SHIFT: the word goes into the hold buffer and hold_full is set.
//   Simultaneous accept + end of word with the hold buffer empty: the new word loads
//     the shifter directly. No gap; the hold buffer stays empty.
//   Simultaneous accept + end of word with hold_full: impossible, since in_ready=0.
//   out_bit is 0 whenever out_valid=0. The detector then sees zeros and does not
//     false-trigger on stale data.
//   Counter width is $clog2(DATA_W). It wraps only through an explicit reload to 0
//     and never counts past DATA_W-1.
//   Throughput: 1 bit per bit_en cycle. Latency from accept to first out_bit is 1 cycle.
// STRUCTURE
//   Shared package seq_pkg holds:
//     the FSM state encoding (SER_IDLE, SER_SHIFT);
//     the detector state constants (IDLE..SEQ_1011), so both stages share one definition.
//   One sub-module, seq_hold_buffer: a one-entry DATA_W register with a full flag and
//     load/unload strobes, async reset.
//   The shifter, bit counter and FSM live in the top module.
// TESTING
//   1. Reset, then in_data=8'hB0, MSB_FIRST=1, bit_en=1:
//      out_bit=1,0,1,1,0,0,0,0 over 8 cycles. frame_done on the 8th cycle.
//      A chained detector raises seq_seen exactly once.
//   2. Back-to-back 8'hA5 then 8'h3C with in_valid held high:
//      16 contiguous out_valid cycles. in_ready drops while the hold buffer is full.
//      frame_done pulses twice, 8 cycles apart.
//   3. bit_en toggled 1,0,1,0 during 8'hB0: each bit holds through its bit_en=0 cycle.
//      The word completes after 16 cycles. No bit is lost or duplicated.
//   4. MSB_FIRST=0, in_data=8'h0D: out_bit=1,0,1,1,0,0,0,0.
//   5. reset asserted asynchronously on the 4th bit of 8'hFF with 8'h0F held:
//      outputs return to reset values immediately and no frame_done is issued.
//      After release, 8'h81 serializes correctly.
//   6. Word accepted on the exact cycle the previous word ends (hold buffer empty):
//      no idle cycle between words, and hold_full never asserts.

Source files
------------

// File: rtl/seq_pkg.sv
//------------------------------------------------------------------------------
// Module  : seq_pkg
// Brief   : Shared state encodings for the bit serializer and the 1011 detector.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package seq_pkg;

    typedef enum logic [0:0] {
        SER_IDLE  = 1'b0,
        SER_SHIFT = 1'b1
    } ser_state_t;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SEQ_1    = 3'd1,
        SEQ_10   = 3'd2,
        SEQ_101  = 3'd3,
        SEQ_1011 = 3'd4
    } det_state_t;

endpackage : seq_pkg

`default_nettype wire

// File: rtl/seq_hold_buffer.sv
//------------------------------------------------------------------------------
// Module  : seq_hold_buffer
// Brief   : One-entry word register with a full flag and load/unload strobes.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module seq_hold_buffer #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_load,
    input  logic              i_unload,
    input  logic [DATA_W-1:0] i_data,
    output logic [DATA_W-1:0] o_data,
    output logic              o_full
);

    logic [DATA_W-1:0] r_data;
    logic              r_full;

    // The producer never loads while full, so load simply wins over unload.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_data <= '0;
            r_full <= 1'b0;
        end else if (i_load) begin
            r_data <= i_data;
            r_full <= 1'b1;
        end else if (i_unload) begin
            r_full <= 1'b0;
        end
    end

    assign o_data = r_data;
    assign o_full = r_full;

endmodule : seq_hold_buffer

`default_nettype wire

// File: rtl/seq_bit_serializer.sv
//------------------------------------------------------------------------------
// Module  : seq_bit_serializer
// Brief   : Parallel-to-serial feeder for the 1011 detector with one-word skid.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module seq_bit_serializer
    import seq_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              bit_en,
    output logic              out_bit,
    output logic              out_valid,
    output logic              frame_done,
    output logic              busy
);

    localparam int                 c_cnt_w = $clog2(DATA_W);
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(DATA_W - 1);

    ser_state_t          r_state;
    logic [DATA_W-1:0]   r_shift;
    logic [c_cnt_w-1:0]  r_cnt;

    logic                w_hold_full;
    logic [DATA_W-1:0]   w_hold_data;
    logic                w_cur_bit;
    logic [DATA_W-1:0]   w_shift_next;
    logic                w_shifting;
    logic                w_accept;
    logic                w_last;
    logic                w_load_direct;
    logic                w_hold_load;
    logic                w_unload;

    generate
        if (MSB_FIRST) begin : g_msb_first
            assign w_cur_bit    = r_shift[DATA_W-1];
            assign w_shift_next = {r_shift[DATA_W-2:0], 1'b0};
        end else begin : g_lsb_first
            assign w_cur_bit    = r_shift[0];
            assign w_shift_next = {1'b0, r_shift[DATA_W-1:1]};
        end
    endgenerate

    assign w_shifting = (r_state == SER_SHIFT);
    assign w_accept   = in_valid & in_ready;
    assign w_last     = w_shifting & bit_en & (r_cnt == c_last);

    // A word goes straight to the shifter whenever the shifter is free this edge.
    assign w_load_direct = w_accept & (~w_shifting | (w_last & ~w_hold_full));
    assign w_hold_load   = w_accept & ~w_load_direct;
    assign w_unload      = w_last & w_hold_full;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= SER_IDLE;
            r_shift <= '0;
            r_cnt   <= '0;
        end else if (w_load_direct) begin
            r_state <= SER_SHIFT;
            r_shift <= in_data;
            r_cnt   <= '0;
        end else if (w_unload) begin
            r_state <= SER_SHIFT;
            r_shift <= w_hold_data;
            r_cnt   <= '0;
        end else if (w_last) begin
            r_state <= SER_IDLE;
            r_shift <= '0;
            r_cnt   <= '0;
        end else if (w_shifting && bit_en) begin
            r_shift <= w_shift_next;
            r_cnt   <= r_cnt + 1'b1;
        end
    end

    seq_hold_buffer #(
        .DATA_W (DATA_W)
    ) u_hold (
        .clk      (clk),
        .reset    (reset),
        .i_load   (w_hold_load),
        .i_unload (w_unload),
        .i_data   (in_data),
        .o_data   (w_hold_data),
        .o_full   (w_hold_full)
    );

    // Zero out_bit when idle so the detector never sees stale shifter contents.
    assign in_ready   = ~w_hold_full;
    assign out_valid  = w_shifting;
    assign out_bit    = w_shifting & w_cur_bit;
    assign frame_done = w_last;
    assign busy       = w_shifting | w_hold_full;

endmodule : seq_bit_serializer

`default_nettype wire
